// File: rtl/ram_mfc_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_mfc_ctrl_if
// MOC/MFC memory bus between a control unit (master) and ram_mfc_ctrl (slave).
//   moc       master -> slave  memory operation command, held until mfc seen
//   rw        master -> slave  1 = read, 0 = write
//   size      master -> slave  00 byte, 01 halfword, 10 word, 11 reserved
//   address   master -> slave  byte address
//   data_in   master -> slave  write data, right-justified
//   data_out  slave  -> master read data, right-justified, zero-extended
//   mfc       slave  -> master memory function complete
//   err       slave  -> master access rejected (valid while mfc = 1)
// ---------------------------------------------------------------------------
interface ram_mfc_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              moc;
  logic              rw;
  logic [1:0]        size;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              mfc;
  logic              err;

  modport master (
    output moc, rw, size, address, data_in,
    input  data_out, mfc, err
  );

  modport slave (
    input  moc, rw, size, address, data_in,
    output data_out, mfc, err
  );
endinterface

// File: rtl/ram_mfc_ctrl.sv
// ---------------------------------------------------------------------------
// ram_mfc_ctrl
// Byte-addressed big-endian RAM behind a MOC/MFC four-phase handshake with
// LATENCY programmable wait states. Byte, halfword and word accesses; bad
// accesses (reserved size, misaligned, past the end) complete with err = 1.
//   main_clk  system clock, rising edge
//   reset     asynchronous, active-high
//   bus       ram_mfc_ctrl_if slave side (moc/rw/size/address/data_in in,
//             data_out/mfc/err out)
//   dbg_addr  debug byte address
//   dbg_data  combinational memory[dbg_addr], 0 when dbg_addr >= DEPTH
// ---------------------------------------------------------------------------
module ram_mfc_ctrl #(
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              main_clk,
  input  logic              reset,
  ram_mfc_ctrl_if.slave     bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;

  // Request fields frozen at capture; later bus changes are ignored.
  logic              rw_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       data_out_q;
  logic              err_q;

  logic [7:0]        memory [0:DEPTH-1];

  logic              capture;
  logic              commit;
  logic              reject;
  logic              misaligned;
  logic [ADDR_W:0]   last_byte;
  logic [1:0]        nb_m1;
  logic [IDX_W-1:0]  i0, i1, i2, i3;
  logic [31:0]       rd_word;

  assign capture = (state == IDLE) && bus.moc;
  // The BUSY->ACK edge is where the access takes effect.
  assign commit  = (state == BUSY) && (cnt == 4'd0);

  // ---------------------------------------------------------------------
  // Access decode from the captured request
  // ---------------------------------------------------------------------
  // NOTE: every always_comb output is given a default first so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    nb_m1      = 2'd0;
    misaligned = 1'b0;
    unique case (size_q)
      2'b01: begin
        nb_m1      = 2'd1;
        misaligned = addr_q[0];
      end
      2'b10: begin
        nb_m1      = 2'd3;
        misaligned = (addr_q[1:0] != 2'b00);
      end
      default: begin
        nb_m1      = 2'd0;
        misaligned = 1'b0;
      end
    endcase
    // One extra bit so the last-byte sum cannot wrap past the address space.
    last_byte = {1'b0, addr_q} + (ADDR_W + 1)'(nb_m1);
    reject    = (size_q == 2'b11) || misaligned ||
                (last_byte >= (ADDR_W + 1)'(DEPTH));
  end

  // Indices are truncated to the array width; they are only used when the
  // access is accepted, in which case all of them are in range.
  assign i0 = addr_q[IDX_W-1:0];
  assign i1 = i0 + IDX_W'(1);
  assign i2 = i0 + IDX_W'(2);
  assign i3 = i0 + IDX_W'(3);

  // Big-endian: the lowest address supplies the most significant byte.
  always_comb begin
    rd_word = 32'd0;
    unique case (size_q)
      2'b00:   rd_word = {24'd0, memory[i0]};
      2'b01:   rd_word = {16'd0, memory[i0], memory[i1]};
      default: rd_word = {memory[i0], memory[i1], memory[i2], memory[i3]};
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.moc) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(LATENCY);
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nxt = ACK;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ACK: begin
        // Holding moc keeps mfc up; a new request needs moc low first.
        if (!bus.moc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Request capture and response registers
  // ---------------------------------------------------------------------
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      rw_q       <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      data_out_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      if (capture) begin
        rw_q    <= bus.rw;
        size_q  <= bus.size;
        addr_q  <= bus.address;
        wdata_q <= bus.data_in;
      end
      if (commit) begin
        err_q      <= reject;
        data_out_q <= (reject || !rw_q) ? 32'd0 : rd_word;
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive reset and only
  // the handshake state is cleared, so an uncommitted write is discarded.
  always_ff @(posedge main_clk) begin
    if (commit && !rw_q && !reject) begin
      unique case (size_q)
        2'b00: memory[i0] <= wdata_q[7:0];
        2'b01: begin
          memory[i0] <= wdata_q[15:8];
          memory[i1] <= wdata_q[7:0];
        end
        default: begin
          memory[i0] <= wdata_q[31:24];
          memory[i1] <= wdata_q[23:16];
          memory[i2] <= wdata_q[15:8];
          memory[i3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign bus.mfc      = (state == ACK);
  assign bus.err      = err_q;
  assign bus.data_out = data_out_q;

  // ---------------------------------------------------------------------
  // Debug byte port
  // ---------------------------------------------------------------------
  always_comb begin
    dbg_data = 8'd0;
    if ({1'b0, dbg_addr} < (ADDR_W + 1)'(DEPTH))
      dbg_data = memory[dbg_addr[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_ram_mfc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_mfc_ctrl
// Two builds: dut_a (DEPTH 512, ADDR_W 9, LATENCY 2) and dut_b (DEPTH 64,
// ADDR_W 7, LATENCY 0). Requests push expected responses into per-DUT
// queues; a monitor pops and compares on every rising mfc.
// ---------------------------------------------------------------------------
module tb_ram_mfc_ctrl;

  localparam int DEPTH_A = 512;
  localparam int DEPTH_B = 64;
  localparam int LAT_A   = 2;
  localparam int LAT_B   = 0;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  ram_mfc_ctrl_if #(.ADDR_W(9)) bus_a ();
  ram_mfc_ctrl_if #(.ADDR_W(7)) bus_b ();

  logic [8:0] dbg_addr_a = '0;
  logic [7:0] dbg_data_a;
  logic [6:0] dbg_addr_b = '0;
  logic [7:0] dbg_data_b;

  ram_mfc_ctrl #(.DEPTH(DEPTH_A), .ADDR_W(9), .LATENCY(LAT_A)) dut_a (
    .main_clk(clk), .reset(rst_a), .bus(bus_a),
    .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a)
  );

  ram_mfc_ctrl #(.DEPTH(DEPTH_B), .ADDR_W(7), .LATENCY(LAT_B)) dut_b (
    .main_clk(clk), .reset(rst_b), .bus(bus_b),
    .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
  );

  typedef struct {
    logic [31:0] data;
    bit          err;
    bit          chk_data;
    int          cap;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [7:0] mem_a [DEPTH_A];
  logic [7:0] mem_b [DEPTH_B];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an access is a list of nb consecutive bytes, MSB first.
  function automatic void model_access(input bit which, input bit rd,
                                       input logic [1:0] sz, input int addr,
                                       input logic [31:0] wd,
                                       output logic [31:0] rdat, output bit er);
    int depth;
    int nb;
    depth = which ? DEPTH_B : DEPTH_A;
    rdat  = 32'd0;
    case (sz)
      2'b00:   nb = 1;
      2'b01:   nb = 2;
      2'b10:   nb = 4;
      default: nb = 0;
    endcase
    if (nb == 0) er = 1'b1;
    else         er = ((addr % nb) != 0) || (addr + nb > depth);
    if (!er) begin
      for (int i = 0; i < nb; i++) begin
        if (rd) begin
          rdat = (rdat << 8) | 32'(which ? mem_b[addr + i] : mem_a[addr + i]);
        end else begin
          if (which) mem_b[addr + i] = 8'(wd >> (8 * (nb - 1 - i)));
          else       mem_a[addr + i] = 8'(wd >> (8 * (nb - 1 - i)));
        end
      end
    end
  endfunction

  function automatic logic get_mfc(input bit which);
    return which ? bus_b.mfc : bus_a.mfc;
  endfunction

  task automatic set_moc(input bit which, input logic v);
    if (which) bus_b.moc = v;
    else       bus_a.moc = v;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic access(input bit which, input bit rd, input logic [1:0] sz,
                        input int addr, input logic [31:0] wd, input int hold);
    exp_t        e;
    logic [31:0] rdat;
    bit          er;
    bit          toggle;
    int          n;
    model_access(which, rd, sz, addr, wd, rdat, er);
    e.data     = er ? 32'd0 : rdat;
    e.err      = er;
    e.chk_data = rd || er;
    e.cap      = cyc + 1;
    toggle     = ($urandom_range(0, 1) == 1);
    if (which) begin
      bus_b.rw = rd; bus_b.size = sz; bus_b.address = addr[6:0];
      bus_b.data_in = wd; bus_b.moc = 1'b1;
      q_b.push_back(e);
    end else begin
      bus_a.rw = rd; bus_a.size = sz; bus_a.address = addr[8:0];
      bus_a.data_in = wd; bus_a.moc = 1'b1;
      q_a.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        // Scramble request fields after capture; the DUT must ignore them.
        if (which) begin
          bus_b.rw = ~rd; bus_b.size = 2'($urandom); bus_b.address = 7'($urandom);
          bus_b.data_in = $urandom;
        end else begin
          bus_a.rw = ~rd; bus_a.size = 2'($urandom); bus_a.address = 9'($urandom);
          bus_a.data_in = $urandom;
          if (toggle) bus_a.moc = 1'b0;
        end
      end
      if (n == 2 && !which) bus_a.moc = 1'b1;
    end while (!get_mfc(which) && n < 40);
    if (!get_mfc(which)) check("mfc_timeout", 32'(get_mfc(which)), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("mfc_held", 32'(get_mfc(which)), 32'd1);
    end
    set_moc(which, 1'b0);
    @(negedge clk);
    check("mfc_drop", 32'(get_mfc(which)), 32'd0);
  endtask

  // Monitor: compare each completed access against its queued expectation.
  logic mfc_a_prev = 1'b0;
  logic mfc_b_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.mfc && !mfc_a_prev) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_mfc", 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        check("a_err", 32'(bus_a.err), 32'(e.err));
        if (e.chk_data) check("a_data", bus_a.data_out, e.data);
        check("a_latency", 32'(cyc - e.cap), 32'(1 + LAT_A));
      end
    end
    if (bus_b.mfc && !mfc_b_prev) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_mfc", 32'd1, 32'd0);
      end else begin
        e = q_b.pop_front();
        check("b_err", 32'(bus_b.err), 32'(e.err));
        if (e.chk_data) check("b_data", bus_b.data_out, e.data);
        check("b_latency", 32'(cyc - e.cap), 32'(1 + LAT_B));
      end
    end
    mfc_a_prev = bus_a.mfc;
    mfc_b_prev = bus_b.mfc;
  end

  task automatic random_access(input bit which);
    int          lim;
    int          addr;
    logic [1:0]  sz;
    lim  = which ? 127 : DEPTH_A - 1;
    sz   = 2'($urandom_range(0, 3));
    addr = $urandom_range(0, lim);
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 2'b01) addr = addr & ~1;
      if (sz == 2'b10) addr = addr & ~3;
    end
    access(which, $urandom_range(0, 1) == 1, sz, addr, $urandom, $urandom_range(0, 2));
  endtask

  initial begin
    bus_a.moc = 1'b0; bus_a.rw = 1'b0; bus_a.size = 2'b00;
    bus_a.address = '0; bus_a.data_in = 32'd0;
    bus_b.moc = 1'b0; bus_b.rw = 1'b0; bus_b.size = 2'b00;
    bus_b.address = '0; bus_b.data_in = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_a_mfc", 32'(bus_a.mfc), 32'd0);
    check("rst_a_err", 32'(bus_a.err), 32'd0);
    check("rst_a_data", bus_a.data_out, 32'd0);
    check("rst_b_mfc", 32'(bus_b.mfc), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // Give both arrays known contents through the write port.
    for (int i = 0; i < DEPTH_A / 4; i++) access(0, 1'b0, 2'b10, 4 * i, $urandom, 0);
    for (int i = 0; i < DEPTH_B / 4; i++) access(1, 1'b0, 2'b10, 4 * i, $urandom, 0);

    // Word write/read, then sub-word reads and a byte write.
    access(0, 1'b0, 2'b10, 8, 32'hDEADBEEF, 0);
    access(0, 1'b1, 2'b10, 8, 32'd0, 0);
    check("mem8_debug", {dut_a.memory[8], dut_a.memory[9],
                         dut_a.memory[10], dut_a.memory[11]}, 32'hDEADBEEF);
    access(0, 1'b1, 2'b00, 9, 32'd0, 0);
    access(0, 1'b1, 2'b01, 10, 32'd0, 0);
    access(0, 1'b0, 2'b00, 11, 32'h55, 0);
    access(0, 1'b1, 2'b10, 8, 32'd0, 0);

    // Rejected accesses, then confirm neighbours are untouched.
    access(0, 1'b1, 2'b10, 6, 32'd0, 0);
    access(0, 1'b1, 2'b01, 3, 32'd0, 0);
    access(0, 1'b1, 2'b11, 8, 32'd0, 0);
    access(0, 1'b1, 2'b10, DEPTH_A - 2, 32'd0, 0);
    access(0, 1'b0, 2'b10, 6, 32'h01020304, 0);
    access(0, 1'b0, 2'b11, 8, 32'h01020304, 0);
    access(0, 1'b1, 2'b10, 4, 32'd0, 0);
    access(0, 1'b1, 2'b10, 8, 32'd0, 0);
    access(0, 1'b1, 2'b01, DEPTH_A - 2, 32'd0, 0);

    // moc held through ACK: one write, one completion.
    access(0, 1'b0, 2'b10, 12, 32'hCAFEF00D, 5);
    access(0, 1'b1, 2'b10, 12, 32'd0, 0);

    // Reset in the middle of a write's wait states.
    bus_a.rw = 1'b0; bus_a.size = 2'b10; bus_a.address = 9'd12;
    bus_a.data_in = 32'h12345678; bus_a.moc = 1'b1;
    @(negedge clk);
    #1 rst_a = 1'b1;
    #1;
    check("midbusy_rst_mfc", 32'(bus_a.mfc), 32'd0);
    check("midbusy_rst_data", bus_a.data_out, 32'd0);
    check("midbusy_rst_err", 32'(bus_a.err), 32'd0);
    bus_a.moc = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    access(0, 1'b1, 2'b10, 12, 32'd0, 0);

    // Zero-latency build: back-to-back reads at both ends.
    access(1, 1'b1, 2'b10, 0, 32'd0, 0);
    access(1, 1'b1, 2'b10, 60, 32'd0, 0);
    access(1, 1'b1, 2'b10, 64, 32'd0, 0);
    access(1, 1'b1, 2'b01, 62, 32'd0, 0);

    for (int i = 0; i < 300; i++) begin
      random_access(0);
      random_access(1);
    end

    for (int i = 0; i < 128; i++) begin
      dbg_addr_b = 7'(i);
      #1;
      check("dbg_b", 32'(dbg_data_b), 32'(i < DEPTH_B ? mem_b[i] : 8'd0));
    end
    for (int i = 0; i < 20; i++) begin
      int a;
      a = $urandom_range(0, DEPTH_A - 1);
      dbg_addr_a = 9'(a);
      #1;
      check("dbg_a", 32'(dbg_data_a), 32'(mem_a[a]));
    end

    @(negedge clk);
    check("q_a_empty", 32'(q_a.size()), 32'd0);
    check("q_b_empty", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
